// File: rtl/gray_rx.sv
// gray_rx: decodes and checks a Gray-coded counter stream (IDLE/TRACK/ERR) with registered outputs.
// Optional feature macro: GRAY_RX_ERRCNT_EN adds the saturating ErrCount output.
module gray_rx #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             Clear,
    output logic [WIDTH-1:0] Binary,
    output logic             Wrap,
    output logic             Restart,
    output logic             Error,
`ifdef GRAY_RX_ERRCNT_EN
    output logic [7:0]       ErrCount,
`endif
    output logic             Locked
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERR
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] dec_d;
    logic [WIDTH-1:0] prev_inc;
    logic             step_hold;
    logic             step_inc;
    logic             step_zero;
    logic             step_illegal;
    logic             prev_max;

    // Each binary bit is the XOR of all Gray bits at and above it (same as the MSB-down cascade).
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign dec_d[i] = ^GrayIn[WIDTH-1:i];
    end

    always_comb begin
        prev_inc     = prev_q + WIDTH'(1);
        prev_max     = (prev_q == '1);
        step_hold    = (dec_d == prev_q);
        step_inc     = (dec_d == prev_inc);
        step_zero    = (dec_d == '0);
        step_illegal = !step_hold && !step_inc && !step_zero;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            prev_q  <= '0;
            Binary  <= '0;
            Wrap    <= 1'b0;
            Restart <= 1'b0;
            Error   <= 1'b0;
            Locked  <= 1'b0;
        end else begin
            Wrap    <= 1'b0;
            Restart <= 1'b0;
            if (Clear) begin
                state_q <= IDLE;
                Error   <= 1'b0;
                Locked  <= 1'b0;
            end else if (Valid) begin
                case (state_q)
                    IDLE: begin
                        prev_q  <= dec_d;
                        Binary  <= dec_d;
                        state_q <= TRACK;
                        Locked  <= 1'b1;
                    end
                    TRACK: begin
                        // A max->0 step matches step_inc first, so it reports Wrap, never Restart.
                        if (step_hold) begin
                            state_q <= TRACK;
                        end else if (step_inc) begin
                            prev_q <= dec_d;
                            Binary <= dec_d;
                            Wrap   <= prev_max;
                        end else if (step_zero) begin
                            prev_q  <= dec_d;
                            Binary  <= dec_d;
                            Restart <= 1'b1;
                        end else begin
                            prev_q  <= dec_d;
                            Binary  <= dec_d;
                            Error   <= 1'b1;
                            state_q <= ERR;
                            Locked  <= 1'b0;
                        end
                    end
                    ERR: begin
                        prev_q <= dec_d;
                        Binary <= dec_d;
                    end
                    default: begin
                        state_q <= IDLE;
                        Locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef GRAY_RX_ERRCNT_EN
    logic err_evt;

    // Illegal steps count in TRACK (the step into ERR) and in ERR alike; Clear drops the sample.
    always_comb begin
        err_evt = Valid && !Clear && (state_q != IDLE) && step_illegal;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ErrCount <= '0;
        end else if (err_evt && (ErrCount != 8'hFF)) begin
            ErrCount <= ErrCount + 8'd1;
        end
    end
`endif

endmodule

// File: doc/gray_rx.md
GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 3: code width in bits, legal range 2..8.
REQ-002 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Valid, input, 1: GrayIn is sampled on this Clk edge.
REQ-005 SHALL have port GrayIn, input, WIDTH: Gray-coded value from the upstream Gray counter.
REQ-006 SHALL have port Clear, input, 1: synchronous pulse; leaves the error state and resynchronises.
REQ-007 SHALL have port Binary, output, WIDTH: registered binary decode of the last accepted sample.
REQ-008 SHALL have port Wrap, output, 1: one-cycle pulse on a legal max->0 step (pairs with the upstream Overflow).
REQ-009 SHALL have port Restart, output, 1: one-cycle pulse on a non-wrap jump to 0 (upstream reset seen).
REQ-010 SHALL have port Error, output, 1: sticky illegal-sequence flag.
REQ-011 SHALL have port Locked, output, 1: high while in state TRACK.
REQ-012 SHALL have port ErrCount, output, 8: saturating illegal-step count; present only per REQ-027.

Function
REQ-013 SHALL decode as: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0.
REQ-014 SHALL register all outputs, with 1-cycle latency from the sampling edge to the output update.
REQ-015 SHALL implement states IDLE, TRACK and ERR; prev holds the last accepted binary value.
REQ-016 IDLE: on Valid, SHALL load prev and Binary with the decode, go to TRACK, and pulse neither Wrap nor Restart.
REQ-017 TRACK, Valid, decode==prev: SHALL treat as a hold (upstream En low), with no pulse, no error and no state change.
REQ-018 TRACK, Valid, decode==prev+1 (mod 2^WIDTH): SHALL accept; if prev==2^WIDTH-1, SHALL pulse Wrap.
REQ-019 TRACK, Valid, decode==0 and prev is not 0 and not max: SHALL accept, pulse Restart, and stay in TRACK.
REQ-020 TRACK, Valid, any other decode: SHALL set Error, update Binary and prev to the decode, and go to ERR.
REQ-021 ERR: SHALL keep Binary following each Valid sample, keep Error high, and keep Wrap and Restart low.
REQ-022 Clear in any state: SHALL clear Error and go to IDLE at the next edge.
REQ-023 Clear together with Valid: Clear SHALL win and the sample SHALL be discarded.
REQ-024 With Valid low, SHALL change no state or output, except that Wrap and Restart SHALL return to 0.
REQ-025 Wrap and Restart SHALL never be high in the same cycle.

Reset
REQ-026 When Reset is low, SHALL asynchronously force state IDLE, prev=0, Binary=0, Wrap=0, Restart=0, Error=0, Locked=0 and ErrCount=0, including mid-stream; after release, the first Valid SHALL follow REQ-016.

Configuration
REQ-027 Macro GRAY_RX_ERRCNT_EN:
- Defined: ErrCount exists and increments by 1 on every REQ-020 event and on every illegal step seen in ERR (decode not prev, prev+1 or 0); it saturates at 255 and is cleared only by Reset.
- Undefined: ErrCount port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 Reset low, then high; Valid=1 with Gray sequence 000,001,011,010,110,111,101,100,000 -> Binary 0..7 then 0, Locked=1 from the 2nd cycle, Wrap pulses once on the final 0, Error=0.
REQ-029 In TRACK with Binary=3, hold GrayIn=010 for 5 Valid cycles -> Binary stays 3, no pulse, Error=0.
REQ-030 In TRACK with Binary=5, apply Gray 000 -> Restart pulses 1 cycle, Binary=0, Locked stays 1, Wrap=0.
REQ-031 In TRACK with Binary=2, apply Gray 110 (binary 4) -> Error=1, state ERR, Locked=0; with the macro defined, ErrCount=1.
REQ-032 In ERR, assert Clear and Valid together with Gray 001 -> sample dropped, Error=0, state IDLE; the next Valid with Gray 011 gives Binary=2 and Locked=1.
REQ-033 Assert Reset low mid-sequence at Binary=6 -> all outputs 0 immediately, without a clock edge; with the macro defined, 300 illegal steps drive ErrCount to 255 and it holds there.
